// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states,
// ALUOp classes and the ALUControl values the ALU understands.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    // Immediate format depends only on the opcode, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_LW, OP_I: return IMM_I;
            OP_SW:       return IMM_S;
            OP_BEQ:      return IMM_B;
            OP_JAL:      return IMM_J;
            default:     return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Signal bundle between the control unit (master) and the datapath (slave):
// instruction fields and zero flag in, mux selects and write enables out.
interface multicycle_control_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, instr_done, illegal_op
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, instr_done, illegal_op
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from the ALUOp class and instruction fields;
// flags funct3 values this core does not implement.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback, and decodes every datapath select and enable.
module multicycle_control
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);

    state_t     state;
    state_t     state_next;
    alu_op_t    alu_op;
    logic       pc_update;
    logic       branch;
    logic       decode_illegal;
    logic       funct_illegal;
    logic [2:0] alu_control;

    // NOTE: sequential state uses non-blocking assignment; combinational logic below uses blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (bus.funct3),
        .op5           (bus.op[5]),
        .funct7b5      (bus.funct7b5),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_next     = S_FETCH;
        alu_op         = ALUOP_ADD;
        pc_update      = 1'b0;
        branch         = 1'b0;
        decode_illegal = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.RegWrite   = 1'b0;
        bus.instr_done = 1'b0;

        case (state)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                pc_update     = 1'b1;
                state_next    = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        decode_illegal = 1'b1;
                        bus.instr_done = 1'b1;
                        state_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_next  = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc  = 2'b01;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc     = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA    = 2'b10;
                alu_op         = ALUOP_SUB;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
                state_next  = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // funct_illegal can only assert while ALUOp is funct, i.e. in an EXECUTE state.
    assign bus.PCWrite    = pc_update | (branch & bus.zero);
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src_of(bus.op);
    assign bus.illegal_op = decode_illegal | funct_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction's per-cycle control
// words come from a reference built from instruction class and cycle index.
module tb_multicycle_control;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] imm_src;
        logic       reg_write;
        logic [2:0] alu_control;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [17:0] actual, input logic [17:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic ctrl_t observed();
        ctrl_t w;
        w.pc_write    = bus.PCWrite;
        w.adr_src     = bus.AdrSrc;
        w.mem_write   = bus.MemWrite;
        w.ir_write    = bus.IRWrite;
        w.result_src  = bus.ResultSrc;
        w.src_a       = bus.ALUSrcA;
        w.src_b       = bus.ALUSrcB;
        w.imm_src     = bus.ImmSrc;
        w.reg_write   = bus.RegWrite;
        w.alu_control = bus.ALUControl;
        w.instr_done  = bus.instr_done;
        w.illegal_op  = bus.illegal_op;
        return w;
    endfunction

    function automatic int cpi(input logic [6:0] op);
        case (op)
            LW:      return 5;
            SW, RT, IT, JAL: return 4;
            BEQ:     return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        case (op)
            LW, IT:  return 2'b00;
            SW:      return 2'b01;
            BEQ:     return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Expected control word for cycle idx (0 = FETCH) of one instruction.
    function automatic ctrl_t ref_word(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7, input logic z, input int idx);
        ctrl_t w = '0;
        w.imm_src = ref_imm(op);
        if (idx == 0) begin
            w.pc_write   = 1'b1;
            w.ir_write   = 1'b1;
            w.src_b      = 2'b10;
            w.result_src = 2'b10;
        end else if (idx == 1) begin
            w.src_a = 2'b01;
            w.src_b = 2'b01;
            if (cpi(op) == 2) begin
                w.illegal_op = 1'b1;
                w.instr_done = 1'b1;
            end
        end else if (op == LW || op == SW) begin
            if (idx == 2) begin
                w.src_a = 2'b10;
                w.src_b = 2'b01;
            end else if (op == SW) begin
                w.adr_src    = 1'b1;
                w.mem_write  = 1'b1;
                w.instr_done = 1'b1;
            end else if (idx == 3) begin
                w.adr_src = 1'b1;
            end else begin
                w.result_src = 2'b01;
                w.reg_write  = 1'b1;
                w.instr_done = 1'b1;
            end
        end else if (op == RT || op == IT) begin
            if (idx == 2) begin
                w.src_a = 2'b10;
                w.src_b = (op == IT) ? 2'b01 : 2'b00;
                case (f3)
                    3'b000:  w.alu_control = (op[5] && f7) ? 3'b001 : 3'b000;
                    3'b010:  w.alu_control = 3'b101;
                    3'b110:  w.alu_control = 3'b011;
                    3'b111:  w.alu_control = 3'b010;
                    default: w.illegal_op  = 1'b1;
                endcase
            end else begin
                w.reg_write  = 1'b1;
                w.instr_done = 1'b1;
            end
        end else if (op == BEQ) begin
            w.src_a       = 2'b10;
            w.alu_control = 3'b001;
            w.pc_write    = z;
            w.instr_done  = 1'b1;
        end else if (op == JAL) begin
            if (idx == 2) begin
                w.src_a    = 2'b01;
                w.src_b    = 2'b10;
                w.pc_write = 1'b1;
            end else begin
                w.reg_write  = 1'b1;
                w.instr_done = 1'b1;
            end
        end
        return w;
    endfunction

    // Enter at posedge+1 with the DUT in FETCH; leave at posedge+1 after the last cycle.
    // zmode 0/1 fixes zero, 2 randomizes it every cycle.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zmode);
        for (int idx = 0; idx < cpi(op); idx++) begin
            bus.op       = op;
            bus.funct3   = f3;
            bus.funct7b5 = f7;
            bus.zero     = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #2;
            check($sformatf("%s op=%b f3=%b c%0d", name, op, f3, idx),
                  observed(), ref_word(op, f3, f7, bus.zero, idx));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] op;
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BEQ; ops[5] = JAL;
        ops[6] = 7'b1111111;

        reset        = 1'b1;
        bus.op       = 7'b0;
        bus.funct3   = 3'b0;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;
        #2;
        check("reset_before_edge", observed(), ref_word(7'b0, 3'b0, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        check("reset_held_over_edge", observed(), ref_word(7'b0, 3'b0, 1'b0, 1'b0, 0));
        reset = 1'b0;

        run_instr("lw",       LW,  3'b010, 1'b0, 2);
        run_instr("sub",      RT,  3'b000, 1'b1, 2);
        run_instr("add",      RT,  3'b000, 1'b0, 2);
        run_instr("beq_take", BEQ, 3'b000, 1'b0, 1);
        run_instr("beq_skip", BEQ, 3'b000, 1'b0, 0);
        run_instr("jal",      JAL, 3'b000, 1'b0, 2);
        run_instr("illegal",  7'b1111111, 3'b000, 1'b0, 2);
        run_instr("slti_bad", IT,  3'b011, 1'b0, 2);
        run_instr("addi_f7",  IT,  3'b000, 1'b1, 2);
        run_instr("sw",       SW,  3'b010, 1'b0, 2);

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 7'b1111111) op = 7'($urandom);
            run_instr("rand", op, 3'($urandom), 1'($urandom), 2);
        end

        // sw abandoned by reset in its MEMADR cycle
        for (int idx = 0; idx < 3; idx++) begin
            bus.op       = SW;
            bus.funct3   = 3'b010;
            bus.funct7b5 = 1'b0;
            bus.zero     = 1'($urandom);
            #2;
            check($sformatf("sw_abort c%0d", idx), observed(),
                  ref_word(SW, 3'b010, 1'b0, bus.zero, idx));
            if (idx < 2) begin
                @(posedge clk);
                #1;
            end
        end
        reset = 1'b1;
        #1;
        check("sw_abort_async_fetch", observed(), ref_word(SW, 3'b010, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        check("sw_abort_no_memwrite", observed(), ref_word(SW, 3'b010, 1'b0, 1'b0, 0));
        reset = 1'b0;
        run_instr("lw_after_reset", LW, 3'b010, 1'b0, 2);
        run_instr("or_after_reset", RT, 3'b110, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle RISC-V core. It sits directly upstream of the ALU and drives `ALUControl` together with every datapath mux select and write enable. The block is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It decodes `ALUControl` from opcode, `funct3` and `funct7[5]`. It supports lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq and jal.

## Interface
Parameters:
- none; opcode, state and ALU encodings are fixed constants in the shared package.

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `op`  in  7  instruction[6:0], taken from the instruction register
- `funct3`  in  3  instruction[14:12]
- `funct7b5`  in  1  instruction[30]
- `zero`  in  1  ALU zero flag, same cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `MemWrite`  out  1  data memory write enable
- `IRWrite`  out  1  instruction register and OldPC enable
- `ResultSrc`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALU result
- `ALUSrcA`  out  2  ALU srcA select: 00 = PC, 01 = OldPC, 10 = register A
- `ALUSrcB`  out  2  ALU srcB select: 00 = register B, 01 = ImmExt, 10 = constant 4
- `ImmSrc`  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- `RegWrite`  out  1  register file write enable
- `ALUControl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct3

## Operation
The state register is the only storage. All outputs are combinational decodes of state, `op`, `funct3`, `funct7b5` and `zero`.

States and transitions:
- FETCH: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, ALUOp=add, `ResultSrc`=10, PCUpdate=1. Next state: DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, ALUOp=add (branch target). Next state by `op`:
  - lw or sw → MEMADR
  - R-type → EXECUTER
  - I-ALU → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - any other `op` → FETCH, with `illegal_op`=1 and `instr_done`=1
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=add. Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `ResultSrc`=00, `AdrSrc`=1. Next state: MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1, `instr_done`=1. Next state: FETCH.
- MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1, `instr_done`=1. Next state: FETCH.
- EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=funct. Next state: ALUWB.
- EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, ALUOp=funct. Next state: ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1, `instr_done`=1. Next state: FETCH.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, ALUOp=sub, `ResultSrc`=00, Branch=1, `instr_done`=1. Next state: FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, ALUOp=add, `ResultSrc`=00, PCUpdate=1. Next state: ALUWB.

Output rules:
- `PCWrite` = PCUpdate | (Branch & `zero`).
- Every output not listed for a state is 0.
- `ImmSrc` decodes from `op` in every state: I for lw and I-ALU, S for sw, B for beq, J for jal, 00 otherwise.

ALU decode:
- ALUOp=add → 000; ALUOp=sub → 001.
- ALUOp=funct, by `funct3`:
  - 000 → 001 if `op`[5] & `funct7b5`, else 000
  - 010 → 101
  - 110 → 011
  - 111 → 010
  - any other value → 000, with `illegal_op`=1 in the EXECUTE state (the instruction still completes)

## Timing
- Reset asserted: state is FETCH immediately, without waiting for a clock. Outputs equal the FETCH decode: `PCWrite`=1, `IRWrite`=1, `ALUSrcB`=10, `ResultSrc`=10, everything else 0. Datapath registers are also held in reset.
- First state advance happens on the first rising edge after `reset` deasserts.
- Reset asserted mid-instruction: the instruction is abandoned and state returns to FETCH asynchronously. No `MemWrite` or `RegWrite` pulse may occur during or after the reset edge.
- Cycles per instruction, counting the FETCH cycle:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - beq 3
  - jal 4
  - illegal 2
- `instr_done` is high for exactly one cycle per instruction.
- `zero` is sampled only in BEQ, combinationally from the same-cycle ALU result.

## Structure
- Package `riscv_pkg`:
  - opcode constants: `OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_BEQ`, `OP_JAL`
  - state enum encoding
  - ALUOp encoding
  - `ALUControl` encodings shared with the ALU
- Sub-module `alu_decoder` (combinational): inputs ALUOp, `funct3`, `op`[5], `funct7b5`; outputs `ALUControl` and the funct-illegal flag.
- Top level: state register, next-state logic and output decode.

## Test plan
- lw (`op`=0000011) after reset release → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `RegWrite`=1 and `ResultSrc`=01 only in cycle 5; `instr_done` in cycle 5.
- sub R-type (`op`=0110011, `funct3`=000, `funct7b5`=1) → `ALUControl`=001 in EXECUTER. With `funct7b5`=0 → 000. Both take 4 cycles.
- beq with `zero`=1 → `PCWrite`=1 in cycle 3. Same instruction with `zero`=0 → `PCWrite`=0 in cycle 3. Both return to FETCH.
- jal → `ALUSrcA`=01, `ALUSrcB`=10 and `PCWrite`=1 in the JAL cycle; `RegWrite`=1 in the ALUWB cycle; 4 cycles total.
- `op`=1111111 → `illegal_op` and `instr_done` pulse in DECODE; FETCH follows next cycle. slti-style `funct3`=011 → `illegal_op` in EXECUTEI.
- sw with `reset` asserted in the MEMADR cycle → FETCH outputs appear before the next edge; `MemWrite` is never 1.
